// File: rtl/mem_arbiter_pkg.sv
// Shared types, widths and arbitration helper for the two-master memory arbiter.
// Word and physical-address widths match the existing 36-bit word / 18-bit address machine.
package mem_arbiter_pkg;

    localparam int WORD_W     = 36;
    localparam int PADDR_W    = 18;
    localparam int PADDR_SIZE = 1 << PADDR_W;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [PADDR_W-1:0] paddr_t;

    typedef enum logic [1:0] {
        MARB_IDLE   = 2'd0,
        MARB_GRANT  = 2'd1,
        MARB_RDATA  = 2'd2,
        MARB_LOCKED = 2'd3
    } marb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Contested grants go to B under fixed priority, otherwise to whoever lost last time.
    function automatic logic pick_winner(input logic req_a, input logic req_b,
                                         input logic last_winner, input logic b_priority);
        if (req_a && !req_b) return PORT_A;
        if (req_b && !req_a) return PORT_B;
        if (b_priority)      return PORT_B;
        return ~last_winner;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-master arbiter (A = CPU, B = DMA/IO) in front of single-ported main memory,
// with RMW bus lock and a no-response timeout that reports nxm to the owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = 255,
    parameter bit B_PRIORITY = 1'b0
) (
    input  logic   clk,
    input  logic   reset,
    input  paddr_t a_addr,
    input  word_t  a_wdata,
    input  logic   a_read,
    input  logic   a_write,
    input  logic   a_lock,
    output logic   a_ack,
    output word_t  a_rdata,
    output logic   a_rvalid,
    output logic   a_nxm,
    input  paddr_t b_addr,
    input  word_t  b_wdata,
    input  logic   b_read,
    input  logic   b_write,
    input  logic   b_lock,
    output logic   b_ack,
    output word_t  b_rdata,
    output logic   b_rvalid,
    output logic   b_nxm,
    output paddr_t mem_addr,
    output word_t  mem_write_data,
    output logic   mem_read,
    output logic   mem_write,
    input  word_t  mem_read_data,
    input  logic   read_ack,
    input  logic   write_ack,
    input  logic   nxm
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    marb_state_t state;
    logic        owner;
    logic        last_winner;
    logic [7:0]  tmo_cnt;
    logic        a_nxm_q;
    logic        b_nxm_q;

    logic   req_a;
    logic   req_b;
    logic   winner;
    logic   own_read;
    logic   own_write;
    logic   own_lock;
    paddr_t own_addr;
    word_t  own_wdata;
    logic   in_grant;
    logic   do_read;
    logic   do_write;
    logic   acked;
    logic   rd_phase;

    assign req_a  = a_read | a_write;
    assign req_b  = b_read | b_write;
    assign winner = pick_winner(req_a, req_b, last_winner, B_PRIORITY);

    assign own_read  = owner ? b_read  : a_read;
    assign own_write = owner ? b_write : a_write;
    assign own_lock  = owner ? b_lock  : a_lock;
    assign own_addr  = owner ? b_addr  : a_addr;
    assign own_wdata = owner ? b_wdata : a_wdata;

    // Read beats write when a master raises both, so the bus never sees both strobes.
    assign in_grant = (state == MARB_GRANT);
    assign do_read  = in_grant & own_read;
    assign do_write = in_grant & own_write & ~own_read;

    assign mem_read       = do_read;
    assign mem_write      = do_write;
    assign mem_addr       = in_grant ? own_addr : '0;
    assign mem_write_data = do_write ? own_wdata : '0;

    // An ack arriving together with nxm or during reset is dropped.
    assign acked = ((do_read & read_ack) | (do_write & write_ack)) & ~nxm & ~reset;
    assign a_ack = acked & (owner == PORT_A);
    assign b_ack = acked & (owner == PORT_B);

    assign rd_phase = (state == MARB_RDATA) & ~reset;
    assign a_rvalid = rd_phase & (owner == PORT_A);
    assign b_rvalid = rd_phase & (owner == PORT_B);
    assign a_rdata  = a_rvalid ? mem_read_data : '0;
    assign b_rdata  = b_rvalid ? mem_read_data : '0;

    assign a_nxm = a_nxm_q;
    assign b_nxm = b_nxm_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= MARB_IDLE;
            owner       <= PORT_A;
            last_winner <= PORT_B;
            tmo_cnt     <= '0;
            a_nxm_q     <= 1'b0;
            b_nxm_q     <= 1'b0;
        end else begin
            a_nxm_q <= 1'b0;
            b_nxm_q <= 1'b0;
            unique case (state)
                MARB_IDLE: begin
                    if (req_a || req_b) begin
                        owner <= winner;
                        state <= MARB_GRANT;
                        if (req_a && req_b) last_winner <= winner;
                    end
                end
                MARB_GRANT: begin
                    if (nxm || (!acked && tmo_cnt == TMO_LAST)) begin
                        tmo_cnt <= '0;
                        state   <= MARB_IDLE;
                        if (owner == PORT_B) b_nxm_q <= 1'b1;
                        else                 a_nxm_q <= 1'b1;
                    end else if (acked) begin
                        tmo_cnt <= '0;
                        if (do_read)       state <= MARB_RDATA;
                        else if (own_lock) state <= MARB_LOCKED;
                        else               state <= MARB_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                MARB_RDATA: begin
                    state <= own_lock ? MARB_LOCKED : MARB_IDLE;
                end
                MARB_LOCKED: begin
                    // Only the owner can leave this state; the other port simply waits.
                    if (own_read || own_write) state <= MARB_GRANT;
                    else if (!own_lock)        state <= MARB_IDLE;
                end
                default: state <= MARB_IDLE;
            endcase
        end
    end

endmodule
